// File: rtl/fc_argmax.sv
// Argmax classifier behind the fully-connected layer: captures all scores on a
// start edge, scans them one per clock and reports the index and value of the largest.
module fc_argmax #(
  parameter int data_width  = 16,
  parameter int numofoutput = 10,
  parameter int idx_width   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [numofoutput*data_width-1:0] f_fc,
  input  logic                              start_flag,
  output logic [idx_width-1:0]              class_idx,
  output logic [data_width-1:0]             max_val,
  output logic                              busy,
  output logic                              over_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [idx_width-1:0] IDX_LAST = idx_width'(numofoutput - 1);

  state_t                        state_r, state_s;
  logic                          start_q_r;
  logic                          start_rise_s;
  logic [idx_width-1:0]          cnt_r, cnt_s;
  logic signed [data_width-1:0]  best_r, best_s;
  logic [idx_width-1:0]          best_idx_r, best_idx_s;
  logic signed [data_width-1:0]  bank_r [numofoutput];
  logic signed [data_width-1:0]  bank_s [numofoutput];
  logic [idx_width-1:0]          class_idx_r, class_idx_s;
  logic signed [data_width-1:0]  max_val_r, max_val_s;
  logic                          busy_r, busy_s;
  logic                          over_flag_r, over_flag_s;
  logic signed [data_width-1:0]  cand_s;
  logic                          gt_s;

  assign start_rise_s = start_flag & ~start_q_r;
  // cnt_r never leaves 0..numofoutput-1, so this read is always in range
  assign cand_s       = bank_r[cnt_r];
  assign gt_s         = cand_s > best_r;

  // Next-state and datapath decisions for the scan FSM
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    best_s      = best_r;
    best_idx_s  = best_idx_r;
    bank_s      = bank_r;
    class_idx_s = class_idx_r;
    max_val_s   = max_val_r;
    busy_s      = busy_r;
    over_flag_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_rise_s) begin
          for (int k = 0; k < numofoutput; k++) begin
            bank_s[k] = f_fc[k*data_width +: data_width];
          end
          best_s     = f_fc[data_width-1:0];
          best_idx_s = '0;
          cnt_s      = idx_width'(1);
          state_s    = SCAN;
          busy_s     = 1'b1;
        end else begin
          busy_s     = 1'b0;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties
        if (gt_s) begin
          best_s     = cand_s;
          best_idx_s = cnt_r;
        end else begin
          best_s     = best_r;
          best_idx_s = best_idx_r;
        end
        if (cnt_r == IDX_LAST) begin
          cnt_s       = '0;
          state_s     = DONE;
          class_idx_s = gt_s ? cnt_r : best_idx_r;
          max_val_s   = gt_s ? cand_s : best_r;
          over_flag_s = 1'b1;
        end else begin
          cnt_s       = cnt_r + idx_width'(1);
          state_s     = SCAN;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      start_q_r   <= 1'b0;
      cnt_r       <= '0;
      best_r      <= '0;
      best_idx_r  <= '0;
      class_idx_r <= '0;
      max_val_r   <= '0;
      busy_r      <= 1'b0;
      over_flag_r <= 1'b0;
      for (int k = 0; k < numofoutput; k++) begin
        bank_r[k] <= '0;
      end
    end else begin
      state_r     <= state_s;
      start_q_r   <= start_flag;
      cnt_r       <= cnt_s;
      best_r      <= best_s;
      best_idx_r  <= best_idx_s;
      class_idx_r <= class_idx_s;
      max_val_r   <= max_val_s;
      busy_r      <= busy_s;
      over_flag_r <= over_flag_s;
      bank_r      <= bank_s;
    end
  end

  assign class_idx = class_idx_r;
  assign max_val   = max_val_r;
  assign busy      = busy_r;
  assign over_flag = over_flag_r;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax (10 scores of 16 bits).
module tb_fc_argmax;
  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*DW-1:0]      f_fc;
  logic                 start_flag;
  logic [IW-1:0]        class_idx;
  logic signed [DW-1:0] max_val;
  logic                 busy;
  logic                 over_flag;

  int errors = 0;
  int checks = 0;
  int sc [N];
  int pulses, p1, p2;

  always #5 clk = ~clk;

  fc_argmax #(.data_width(DW), .numofoutput(N), .idx_width(IW)) dut (
    .clk(clk), .rst(rst), .f_fc(f_fc), .start_flag(start_flag),
    .class_idx(class_idx), .max_val(max_val), .busy(busy), .over_flag(over_flag)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < N; k++) f_fc[k*DW +: DW] = sc[k][DW-1:0];
  endtask

  // Called at the negedge just before E0 with start_flag already high
  task automatic run_scan(input string tag, input int exp_idx, input int exp_val,
                          input bit drop_start, input bit zero_fc, input bit glitch);
    int np, pc;
    np = 0;
    pc = -1;
    @(negedge clk);
    check({tag, " busy@E0"}, busy, 1);
    if (drop_start) start_flag = 1'b0;
    if (zero_fc) f_fc = '0;
    for (int k = 1; k <= 12; k++) begin
      if (glitch && k == 3) start_flag = 1'b1;
      if (glitch && k == 4) start_flag = 1'b0;
      @(negedge clk);
      if (over_flag === 1'b1) begin
        np++;
        if (pc < 0) pc = k;
      end
      if (k == 9) begin
        check({tag, " class_idx"}, class_idx, exp_idx);
        check({tag, " max_val"}, max_val, exp_val);
      end
      if (k == 10) check({tag, " busy@E10"}, busy, 0);
    end
    check({tag, " pulses"}, np, 1);
    check({tag, " pulse_cycle"}, pc, 9);
  endtask

  initial begin
    rst = 1'b1;
    start_flag = 1'b0;
    f_fc = '0;
    repeat (2) @(negedge clk);
    check("rst class_idx", class_idx, 0);
    check("rst max_val", max_val, 0);
    check("rst busy", busy, 0);
    check("rst over_flag", over_flag, 0);
    rst = 1'b0;
    @(negedge clk);

    sc = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    pack();
    start_flag = 1'b1;
    run_scan("mixed", 2, 7, 1'b1, 1'b0, 1'b0);

    sc = '{-9, -3, -8, -3, -20, -4, -7, -6, -5, -10};
    pack();
    start_flag = 1'b1;
    run_scan("negative", 1, -3, 1'b1, 1'b0, 1'b0);

    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    pack();
    start_flag = 1'b1;
    run_scan("last_max", 9, 100, 1'b1, 1'b0, 1'b0);

    // Held start plus f_fc wiped after capture
    sc = '{5, 1, 2, 3, 4, 8, 0, 0, 0, 0};
    pack();
    start_flag = 1'b1;
    run_scan("held", 5, 8, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (over_flag === 1'b1) pulses++;
    end
    check("held extra_pulses", pulses, 0);
    check("held busy", busy, 0);
    start_flag = 1'b0;
    @(negedge clk);

    sc = '{-32768, -1, 0, 32766, -32768, 32767, 32767, 0, -32768, 1};
    pack();
    start_flag = 1'b1;
    run_scan("extremes", 5, 32767, 1'b1, 1'b0, 1'b1);
    check("glitch busy_after", busy, 0);

    sc = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
    pack();
    start_flag = 1'b1;
    run_scan("equal", 0, 42, 1'b1, 1'b0, 1'b0);

    // Back-to-back: retrigger lands on E11
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    pack();
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    pulses = 0;
    p1 = -1;
    p2 = -1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (over_flag === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = k;
        else p2 = k;
      end
      if (k == 9) begin
        check("b2b first class_idx", class_idx, 8);
        check("b2b first max_val", max_val, 9);
      end
      if (k == 10) begin
        sc = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0};
        pack();
        start_flag = 1'b1;
      end
      if (k == 11) begin
        start_flag = 1'b0;
        check("b2b busy@E11", busy, 1);
        check("b2b hold@E11", class_idx, 8);
      end
      if (k == 19) check("b2b hold@E19", class_idx, 8);
      if (k == 20) begin
        check("b2b second class_idx", class_idx, 3);
        check("b2b second max_val", max_val, 50);
      end
    end
    check("b2b pulses", pulses, 2);
    check("b2b first_cycle", p1, 9);
    check("b2b second_cycle", p2, 20);

    // Reset in the middle of a scan
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    pack();
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort class_idx", class_idx, 0);
    check("abort max_val", max_val, 0);
    check("abort busy", busy, 0);
    check("abort over_flag", over_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (over_flag === 1'b1) pulses++;
    end
    check("abort no_pulse", pulses, 0);

    // start_flag already high when reset releases
    rst = 1'b1;
    start_flag = 1'b1;
    sc = '{-5, -6, -7, -8, -9, -1, -2, -3, -4, -10};
    pack();
    @(negedge clk);
    rst = 1'b0;
    run_scan("start_at_release", 5, -1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
